// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg : shared encodings for the IF/D memory port arbiter
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_D  = 2'd2;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/arb_prio_sel.sv
// ---------------------------------------------------------------------------
// arb_prio_sel : D-over-IF priority select with anti-starvation counter
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arb_prio_sel #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic idle_i,
  input  logic arb_en_i,
  input  logic if_cand_i,
  input  logic d_cand_i,
  input  logic if_req_i,
  output logic grant_if_o,
  output logic grant_d_o
);

  localparam int CTR_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CTR_W-1:0] C_MAX = CTR_W'(STARVE_MAX);

  logic [CTR_W-1:0] starve_q, starve_d;
  logic             force_if;

  assign force_if   = (starve_q == C_MAX) && if_cand_i;
  assign grant_if_o = arb_en_i && if_cand_i && (!d_cand_i || force_if);
  assign grant_d_o  = arb_en_i && d_cand_i && !grant_if_o;

  // Counts D wins that bypassed a waiting fetch; raw if_req decides "waiting".
  always_comb begin
    starve_d = starve_q;
    if (grant_if_o) begin
      starve_d = '0;
    end else if (grant_d_o && if_req_i) begin
      if (starve_q != C_MAX) starve_d = starve_q + CTR_W'(1);
    end else if (idle_i && !if_req_i) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : shares one memory port between instruction fetch and data
// Build option     : MEM_ARB_BACK_TO_BACK_EN re-arbitrates in the ack cycle
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  logic [1:0]        state_q, state_d;
  logic              kill_pend_q, kill_pend_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic   idle, busy_if, busy_d, ack_if, ack_d, done;
  logic   arb_en, if_cand, d_cand;
  logic   grant_if, grant_d, grant_any;
  owner_t sel_own;

  assign idle    = (state_q == ST_IDLE);
  assign busy_if = (state_q == ST_BUSY_IF);
  assign busy_d  = (state_q == ST_BUSY_D);
  assign ack_if  = busy_if && mem_ack;
  assign ack_d   = busy_d && mem_ack;
  assign done    = ack_if || ack_d;

`ifdef MEM_ARB_BACK_TO_BACK_EN
  // The finishing owner is excluded: its req is still high during its own ack.
  assign arb_en  = idle || done;
  assign if_cand = if_req && !if_kill && !busy_if;
  assign d_cand  = d_req && !busy_d;
`else
  assign arb_en  = idle;
  assign if_cand = if_req && !if_kill;
  assign d_cand  = d_req;
`endif

  arb_prio_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk        (clk),
    .reset      (reset),
    .idle_i     (idle),
    .arb_en_i   (arb_en),
    .if_cand_i  (if_cand),
    .d_cand_i   (d_cand),
    .if_req_i   (if_req),
    .grant_if_o (grant_if),
    .grant_d_o  (grant_d)
  );

  assign grant_any = grant_if || grant_d;
  assign sel_own   = grant_d ? OWN_D : OWN_IF;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) state_d = (sel_own == OWN_D) ? ST_BUSY_D : ST_BUSY_IF;
      end
      ST_BUSY_IF, ST_BUSY_D: begin
        if (mem_ack) begin
          if (grant_any) state_d = (sel_own == OWN_D) ? ST_BUSY_D : ST_BUSY_IF;
          else           state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    if_ready = !reset && ack_if && !kill_pend_q && !if_kill;
    d_ready  = !reset && ack_d;
    if_rdata = busy_if ? mem_rdata : '0;
    d_rdata  = busy_d ? mem_rdata : '0;
  end

  // Request fields are captured once at grant and held until the ack.
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (grant_any) begin
      mem_req_d = 1'b1;
      if (sel_own == OWN_D) begin
        mem_we_d    = d_we;
        mem_be_d    = d_be;
        mem_addr_d  = d_addr;
        mem_wdata_d = d_wdata;
      end else begin
        mem_we_d    = 1'b0;
        mem_be_d    = '1;
        mem_addr_d  = if_addr;
        mem_wdata_d = '0;
      end
    end else if (done) begin
      mem_req_d = 1'b0;
    end
  end

  always_comb begin
    kill_pend_d = kill_pend_q;
    if (ack_if)                  kill_pend_d = 1'b0;
    else if (busy_if && if_kill) kill_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kill_pend_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      kill_pend_q <= kill_pend_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire
